// File: rtl/secuenciador_suma.sv
// rtl/secuenciador_suma.sv - keypad sequencer for a two-operand decimal adder
//
// Collects up to MAX_DIGITOS digits for each operand from a keypad, steers
// load/clear pulses to the operand registers, selects the display source and
// shows the sum until a new digit or a clear key starts the next operation.
//
// Optional feature: define SECUENCIADOR_SUMA_TIMEOUT_EN to auto-clear the
// displayed sum after TIMEOUT_CICLOS idle cycles.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   tecla_in     key code: 0-9 digit, A '+', B '=', C clear, D-F unused
//   tecla_pulso  one-cycle strobe qualifying tecla_in
//   digito_out   digit presented to the operand registers (held between loads)
//   carga_num1   one-cycle load pulse, operand 1
//   carga_num2   one-cycle load pulse, operand 2
//   limpiar      one-cycle clear pulse, both operands
//   sel_display  display source: 00 operand 1, 01 operand 2, 10 sum
//   listo        high while the sum is displayed
//   rechazo      one-cycle pulse when a key is refused
//   estado_out   current state code (debug)

module secuenciador_suma #(
    parameter int MAX_DIGITOS    = 3,
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tecla_in,
    input  logic       tecla_pulso,
    output logic [3:0] digito_out,
    output logic       carga_num1,
    output logic       carga_num2,
    output logic       limpiar,
    output logic [1:0] sel_display,
    output logic       listo,
    output logic       rechazo,
    output logic [2:0] estado_out
);

    localparam int CW = $clog2(MAX_DIGITOS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITOS);
    localparam logic [CW-1:0] UNO     = CW'(1);

    localparam logic [1:0] SEL_NUM1 = 2'b00;
    localparam logic [1:0] SEL_NUM2 = 2'b01;
    localparam logic [1:0] SEL_SUMA = 2'b10;

    if (MAX_DIGITOS < 1 || TIMEOUT_CICLOS < 1) begin : g_cfg_invalida
        $error("secuenciador_suma: MAX_DIGITOS and TIMEOUT_CICLOS must be >= 1");
    end

    typedef enum logic [2:0] {
        CAP1    = 3'd0,
        CAP2    = 3'd1,
        SUMA    = 3'd2,
        MUESTRA = 3'd3,
        LIMPIA  = 3'd4
    } estado_t;

    estado_t       estado, estado_sig;
    logic [CW-1:0] cnt1, cnt1_sig;
    logic [CW-1:0] cnt2, cnt2_sig;
    logic [3:0]    pendiente, pendiente_sig;

    logic [3:0] digito_sig;
    logic       carga1_sig, carga2_sig, limpiar_sig, rechazo_sig, listo_sig;
    logic [1:0] sel_sig;
    logic       borrar;

    logic es_digito, es_mas, es_igual, es_borrar;

    assign es_digito = (tecla_in <= 4'd9);
    assign es_mas    = (tecla_in == 4'hA);
    assign es_igual  = (tecla_in == 4'hB);
    assign es_borrar = (tecla_in == 4'hC);

    assign estado_out = estado;

`ifdef SECUENCIADOR_SUMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

    logic [TW-1:0] ocio, ocio_sig;
    logic          vencido;

    // Idle count restarts on any key and whenever MUESTRA is not active, so
    // each visit to MUESTRA starts from zero.
    assign vencido = (ocio == TW'(TIMEOUT_CICLOS - 1));

    always_comb begin
        ocio_sig = '0;
        if (estado == MUESTRA && !tecla_pulso && !vencido) begin
            ocio_sig = ocio + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ocio <= '0;
        end else begin
            ocio <= ocio_sig;
        end
    end
`endif

    always_comb begin
        estado_sig    = estado;
        cnt1_sig      = cnt1;
        cnt2_sig      = cnt2;
        pendiente_sig = pendiente;
        digito_sig    = digito_out;
        carga1_sig    = 1'b0;
        carga2_sig    = 1'b0;
        limpiar_sig   = 1'b0;
        rechazo_sig   = 1'b0;
        sel_sig       = sel_display;
        listo_sig     = listo;
        borrar        = 1'b0;

        case (estado)
            CAP1: begin
                if (tecla_pulso) begin
                    if (es_digito) begin
                        if (cnt1 < MAX_CNT) begin
                            digito_sig = tecla_in;
                            carga1_sig = 1'b1;
                            cnt1_sig   = cnt1 + UNO;
                        end else begin
                            rechazo_sig = 1'b1;
                        end
                    end else if (es_mas) begin
                        if (cnt1 != '0) begin
                            estado_sig = CAP2;
                            sel_sig    = SEL_NUM2;
                        end else begin
                            rechazo_sig = 1'b1;
                        end
                    end else if (es_igual) begin
                        rechazo_sig = 1'b1;
                    end else if (es_borrar) begin
                        borrar = 1'b1;
                    end
                end
            end

            CAP2: begin
                if (tecla_pulso) begin
                    if (es_digito) begin
                        if (cnt2 < MAX_CNT) begin
                            digito_sig = tecla_in;
                            carga2_sig = 1'b1;
                            cnt2_sig   = cnt2 + UNO;
                        end else begin
                            rechazo_sig = 1'b1;
                        end
                    end else if (es_mas) begin
                        rechazo_sig = 1'b1;
                    end else if (es_igual) begin
                        if (cnt2 != '0) begin
                            estado_sig = SUMA;
                        end else begin
                            rechazo_sig = 1'b1;
                        end
                    end else if (es_borrar) begin
                        borrar = 1'b1;
                    end
                end
            end

            // One cycle for the external adder to settle; keys are dropped.
            SUMA: begin
                estado_sig = MUESTRA;
                sel_sig    = SEL_SUMA;
                listo_sig  = 1'b1;
            end

            MUESTRA: begin
                if (tecla_pulso) begin
                    if (es_digito) begin
                        // The digit starts a new operand 1, but only after
                        // the registers have been cleared in LIMPIA.
                        pendiente_sig = tecla_in;
                        limpiar_sig   = 1'b1;
                        estado_sig    = LIMPIA;
                    end else if (es_mas || es_igual) begin
                        rechazo_sig = 1'b1;
                    end else if (es_borrar) begin
                        borrar = 1'b1;
                    end
                end
`ifdef SECUENCIADOR_SUMA_TIMEOUT_EN
                else if (vencido) begin
                    borrar = 1'b1;
                end
`endif
            end

            // Keys are dropped here; the stored digit becomes the first
            // digit of the new operand 1.
            LIMPIA: begin
                digito_sig = pendiente;
                carga1_sig = 1'b1;
                cnt1_sig   = UNO;
                cnt2_sig   = '0;
                estado_sig = CAP1;
                sel_sig    = SEL_NUM1;
                listo_sig  = 1'b0;
            end

            default: begin
                estado_sig = CAP1;
            end
        endcase

        if (borrar) begin
            limpiar_sig = 1'b1;
            cnt1_sig    = '0;
            cnt2_sig    = '0;
            estado_sig  = CAP1;
            sel_sig     = SEL_NUM1;
            listo_sig   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= CAP1;
            cnt1        <= '0;
            cnt2        <= '0;
            pendiente   <= '0;
            digito_out  <= '0;
            carga_num1  <= 1'b0;
            carga_num2  <= 1'b0;
            limpiar     <= 1'b0;
            rechazo     <= 1'b0;
            sel_display <= SEL_NUM1;
            listo       <= 1'b0;
        end else begin
            estado      <= estado_sig;
            cnt1        <= cnt1_sig;
            cnt2        <= cnt2_sig;
            pendiente   <= pendiente_sig;
            digito_out  <= digito_sig;
            carga_num1  <= carga1_sig;
            carga_num2  <= carga2_sig;
            limpiar     <= limpiar_sig;
            rechazo     <= rechazo_sig;
            sel_display <= sel_sig;
            listo       <= listo_sig;
        end
    end

endmodule

// File: doc/secuenciador_suma.md
SECUENCIADOR_SUMA -- requirements
Module: secuenciador_suma

Interface
REQ-001 SHALL have parameter MAX_DIGITOS, default 3, maximum digits accepted per operand.
REQ-002 SHALL have parameter TIMEOUT_CICLOS, default 50_000_000, idle cycles before auto-clear when the timeout feature is compiled in.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port tecla_in  input  4  key code from the keypad encoder: 0-9 digit, A '+', B '=', C clear, D-F unused.
REQ-006 SHALL have port tecla_pulso  input  1  one-cycle strobe; tecla_in is valid when high.
REQ-007 SHALL have port digito_out  output  4  digit presented to the operand registers.
REQ-008 SHALL have port carga_num1  output  1  one-cycle load pulse to the operand-1 register.
REQ-009 SHALL have port carga_num2  output  1  one-cycle load pulse to the operand-2 register.
REQ-010 SHALL have port limpiar  output  1  one-cycle clear pulse to both operand registers.
REQ-011 SHALL have port sel_display  output  2  display source: 00 operand 1, 01 operand 2, 10 sum, 11 reserved.
REQ-012 SHALL have port listo  output  1  high while the sum is displayed.
REQ-013 SHALL have port rechazo  output  1  one-cycle pulse when a key is refused.
REQ-014 SHALL have port estado_out  output  3  current state code, for debug.

Function
REQ-015 SHALL implement states CAP1=0, CAP2=1, SUMA=2, MUESTRA=3, LIMPIA=4, driven on estado_out.
REQ-016 SHALL register all outputs: a key sampled at edge N produces its pulses during the cycle after edge N; every pulse lasts exactly one cycle.
REQ-017 SHALL keep digit counters cnt1 and cnt2, each ranging from 0 to MAX_DIGITOS.
REQ-018 CAP1, digit, cnt1<MAX_DIGITOS: digito_out=key, carga_num1 pulse, cnt1+1.
REQ-019 CAP1, digit, cnt1==MAX_DIGITOS: rechazo pulse only, no load.
REQ-020 CAP1, '+': if cnt1>=1 go to CAP2 with sel_display=01; if cnt1==0 pulse rechazo.
REQ-021 CAP1, '=': rechazo pulse.
REQ-022 CAP2, digit: same rules as CAP1, using carga_num2 and cnt2.
REQ-023 CAP2, '+': rechazo pulse.
REQ-024 CAP2, '=': if cnt2>=1 go to SUMA; if cnt2==0 pulse rechazo.
REQ-025 SUMA SHALL last exactly one cycle for adder settling, then go to MUESTRA with sel_display=10 and listo=1.
REQ-026 MUESTRA, digit:
- store the digit and go to LIMPIA with a limpiar pulse;
- on the next cycle, load the stored digit with carga_num1, set cnt1=1, cnt2=0, and go to CAP1 with sel_display=00 and listo=0.
REQ-027 MUESTRA, '+' or '=': rechazo pulse, state held.
REQ-028 Key 'C' in CAP1, CAP2 or MUESTRA SHALL produce a limpiar pulse, clear cnt1 and cnt2, and go to CAP1 with sel_display=00 and listo=0.
REQ-029 Keys D-F SHALL be ignored in every state, with no rechazo pulse.
REQ-030 tecla_pulso during SUMA or LIMPIA SHALL be dropped silently; this is the only simultaneous-event case.
REQ-031 carga_num1, carga_num2 and limpiar SHALL never be high in the same cycle.
REQ-032 digito_out SHALL hold its last value when no load pulse is active.

Reset
REQ-033 Asserting reset SHALL immediately force:
- state CAP1 and cnt1=cnt2=0;
- digito_out=0, carga_num1=0, carga_num2=0, limpiar=0;
- sel_display=00, listo=0, rechazo=0, estado_out=0.
REQ-034 Reset asserted mid-sequence (including in SUMA or LIMPIA) SHALL discard any pending digit and SHALL NOT emit a pulse on release.
REQ-035 The first edge after reset release SHALL already accept a key.

Configuration
REQ-036 With macro SECUENCIADOR_SUMA_TIMEOUT_EN defined, MUESTRA SHALL count idle cycles.
- Any tecla_pulso restarts the count.
- When the count reaches TIMEOUT_CICLOS, the block SHALL pulse limpiar, clear both counters, and go to CAP1 with listo=0.
REQ-037 Without SECUENCIADOR_SUMA_TIMEOUT_EN, MUESTRA SHALL persist indefinitely and no timeout counter SHALL be synthesized.

Verification
REQ-038 Keys 1,2,A,3,B: carga_num1 twice with digito_out 1 then 2; carga_num2 once with digit 3; SUMA for one cycle; then sel_display=10 and listo=1.
REQ-039 With MAX_DIGITOS=3, keys 9,9,9,9: three carga_num1 pulses, and the fourth key yields rechazo with no load.
REQ-040 Reset state followed by key A, then key B: two rechazo pulses; estado_out stays 0.
REQ-041 In MUESTRA, key 7: limpiar in cycle N+1 and carga_num1 with digito_out=7 in N+2, then CAP1 with cnt1=1.
REQ-042 Key C in CAP2 after digits 4,A,5: limpiar pulse, state CAP1, sel_display=00; next digit loads num1.
REQ-043 With SECUENCIADOR_SUMA_TIMEOUT_EN and TIMEOUT_CICLOS=8: an idle MUESTRA auto-clears after 8 cycles; a key at cycle 5 restarts the count.
